pc_sequencer: RTL and testbench

// - Fetch/next-PC sequencer: owns PC, fetches from instruction memory via req/gnt/rvalid, presents inst to decode/EX.
// - Consumes EX results (alu_c, alu_zero, alu_sgn) in the execute cycle; resolves branch/jump; commits next PC.
// - Multi-cycle, one instruction in flight; traps (halts) on a misaligned fetch target.

---
 rtl/pc_sequencer_pkg.sv | 19 +
 rtl/pc_sequencer_npc_calc.sv | 40 ++++
 rtl/pc_sequencer.sv | 121 ++++++++++++
 tb/tb_pc_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch/next-PC sequencer.
// Next-PC select codes driven by the decoder.
package pc_sequencer_pkg;

  localparam logic [2:0] NPC_PC4  = 3'd0;
  localparam logic [2:0] NPC_BEQ  = 3'd1;
  localparam logic [2:0] NPC_BNE  = 3'd2;
  localparam logic [2:0] NPC_BLT  = 3'd3;
  localparam logic [2:0] NPC_BGE  = 3'd4;
  localparam logic [2:0] NPC_JAL  = 3'd5;
  localparam logic [2:0] NPC_JALR = 3'd6;

  function automatic logic misaligned(
    input logic [31:0] a
  );
    return a[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_sequencer_npc_calc.sv
// Combinational next-PC resolver.
// Branch/jump targets wrap modulo 2^32.
module npc_calc
  import pc_sequencer_pkg::*;
#(
  parameter bit JALR_CLR_LSB = 1'b1
) (
  input  logic [31:0] pc,
  input  logic [2:0]  npc_op,
  input  logic [31:0] sext_ext,
  input  logic [31:0] alu_c,
  input  logic        zero,
  input  logic        sgn,
  output logic [31:0] npc,
  output logic [31:0] pc4
);

  logic [31:0] br_tgt;
  logic [31:0] jalr_mask;

  assign pc4       = pc + 32'd4;
  assign br_tgt    = pc + sext_ext;
  assign jalr_mask = ~{31'b0, JALR_CLR_LSB};

  // Select the committed next PC; unknown ops fall through.
  always_comb begin
    npc = pc4;
    unique case (npc_op)
      NPC_PC4:  npc = pc4;
      NPC_BEQ:  npc = zero ? br_tgt : pc4;
      NPC_BNE:  npc = zero ? pc4 : br_tgt;
      NPC_BLT:  npc = sgn ? br_tgt : pc4;
      NPC_BGE:  npc = sgn ? pc4 : br_tgt;
      NPC_JAL:  npc = br_tgt;
      NPC_JALR: npc = alu_c & jalr_mask;
      default:  npc = pc4;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/next-PC sequencer, one instruction in flight.
// Halts in TRAP on a misaligned committed PC.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter bit          JALR_CLR_LSB = 1'b1
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst_n,
  input  logic [2:0]  npc_op,
  input  logic [31:0] sext_ext,
  input  logic [31:0] alu_c,
  input  logic        alu_zero,
  input  logic        alu_sgn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        misalign
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_EXEC,
    S_TRAP
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] npc;
  logic        inst_ld;

  npc_calc #(
    .JALR_CLR_LSB(JALR_CLR_LSB)
  ) u_npc (
    .pc      (pc),
    .npc_op  (npc_op),
    .sext_ext(sext_ext),
    .alu_c   (alu_c),
    .zero    (alu_zero),
    .sgn     (alu_sgn),
    .npc     (npc),
    .pc4     (pc4)
  );

  // State register; reset overrides every other event.
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, handshake outputs and load enables.
  always_comb begin
    state_nxt  = state;
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    misalign   = 1'b0;
    inst_ld    = 1'b0;
    unique case (state)
      S_IDLE: begin
        state_nxt = S_REQ;
      end
      S_REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) begin
          if (imem_rvalid) begin
            inst_ld   = 1'b1;
            state_nxt = S_EXEC;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          inst_ld   = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        inst_valid = 1'b1;
        state_nxt  = misaligned(npc) ? S_TRAP : S_REQ;
      end
      S_TRAP: begin
        misalign = 1'b1;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign imem_addr = pc;

  // PC commits in EXEC; instruction latches on accepted data.
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst_n) begin
      pc   <= RESET_PC;
      inst <= 32'h0;
    end else begin
      if (state == S_EXEC) begin
        pc <= npc;
      end
      if (inst_ld) begin
        inst <= imem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer.
// Reference model tracks the architectural PC only.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        cpu_clk;
  logic        cpu_rst_n;
  logic [2:0]  npc_op;
  logic [31:0] sext_ext;
  logic [31:0] alu_c;
  logic        alu_zero;
  logic        alu_sgn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        misalign;

  int total;
  int passed;
  logic [31:0] mpc;

  pc_sequencer #(
    .RESET_PC    (RST_PC),
    .JALR_CLR_LSB(1'b1)
  ) dut (
    .cpu_clk    (cpu_clk),
    .cpu_rst_n  (cpu_rst_n),
    .npc_op     (npc_op),
    .sext_ext   (sext_ext),
    .alu_c      (alu_c),
    .alu_zero   (alu_zero),
    .alu_sgn    (alu_sgn),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .inst_valid (inst_valid),
    .pc         (pc),
    .pc4        (pc4),
    .misalign   (misalign)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
  endtask

  // Architectural next-PC rule: taken decision, then target.
  function automatic logic [31:0] ref_npc(
    input logic [2:0]  op,
    input logic [31:0] p,
    input logic [31:0] off,
    input logic [31:0] base,
    input logic        z,
    input logic        s
  );
    logic taken;
    longint sum;
    taken = 1'b0;
    case (op)
      3'd1: taken = z;
      3'd2: taken = !z;
      3'd3: taken = s;
      3'd4: taken = !s;
      3'd5: taken = 1'b1;
      default: taken = 1'b0;
    endcase
    if (op == 3'd6) return {base[31:1], 1'b0};
    if (taken) sum = longint'(p) + longint'(off);
    else sum = longint'(p) + 4;
    return sum[31:0];
  endfunction

  task automatic tick();
    @(posedge cpu_clk);
    @(negedge cpu_clk);
  endtask

  task automatic do_reset();
    cpu_rst_n = 1'b0;
    tick();
    cpu_rst_n = 1'b1;
    mpc = RST_PC;
    chk("rst_pc", pc, RST_PC);
    chk("rst_inst", inst, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_ivld", {31'b0, inst_valid}, 32'h0);
    chk("rst_mis", {31'b0, misalign}, 32'h0);
    tick();
  endtask

  // From REQ: stall gnt, deliver data, land in EXEC.
  task automatic fetch(input logic [31:0] rd,
                       input int gdly,
                       input int wdly,
                       input bit same);
    chk("req", {31'b0, imem_req}, 32'h1);
    chk("addr", imem_addr, mpc);
    imem_gnt = 1'b0;
    for (int i = 0; i < gdly; i++) begin
      tick();
      chk("req_hold", {31'b0, imem_req}, 32'h1);
      chk("addr_hold", imem_addr, mpc);
    end
    imem_gnt    = 1'b1;
    imem_rvalid = same;
    imem_rdata  = rd;
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    if (!same) begin
      chk("wait_req", {31'b0, imem_req}, 32'h0);
      for (int i = 0; i < wdly; i++) begin
        imem_rdata = $urandom;
        tick();
        chk("wait_ivld", {31'b0, inst_valid}, 32'h0);
      end
      imem_rvalid = 1'b1;
      imem_rdata  = rd;
      tick();
      imem_rvalid = 1'b0;
    end
    chk("ivld", {31'b0, inst_valid}, 32'h1);
    chk("inst", inst, rd);
    chk("pc", pc, mpc);
    chk("pc4", pc4, mpc + 32'd4);
  endtask

  // In EXEC: drive EX results, commit, check landing.
  task automatic exec(input logic [2:0]  op,
                      input logic [31:0] off,
                      input logic [31:0] base,
                      input logic        z,
                      input logic        s);
    logic [31:0] e;
    npc_op   = op;
    sext_ext = off;
    alu_c    = base;
    alu_zero = z;
    alu_sgn  = s;
    e = ref_npc(op, mpc, off, base, z, s);
    tick();
    mpc = e;
    chk("npc", pc, e);
    chk("ivld_lo", {31'b0, inst_valid}, 32'h0);
    if (e[1:0] != 2'b00) begin
      chk("trap_mis", {31'b0, misalign}, 32'h1);
      chk("trap_req", {31'b0, imem_req}, 32'h0);
    end else begin
      chk("nxt_req", {31'b0, imem_req}, 32'h1);
      chk("nxt_mis", {31'b0, misalign}, 32'h0);
    end
  endtask

  task automatic goto(input logic [31:0] a);
    fetch(32'h0000_0067, 0, 0, 1'b1);
    exec(3'd6, 32'h0, a, 1'b0, 1'b0);
  endtask

  task automatic br(input logic [2:0] op,
                    input logic z,
                    input logic s,
                    input logic [31:0] want);
    goto(32'h100);
    fetch(32'h0000_0063, 0, 0, 1'b0);
    exec(op, 32'hFFFF_FFF0, 32'h0, z, s);
    chk("br_const", pc, want);
  endtask

  initial begin
    total       = 0;
    passed      = 0;
    mpc         = RST_PC;
    cpu_rst_n   = 1'b0;
    npc_op      = 3'd0;
    sext_ext    = 32'h0;
    alu_c       = 32'h0;
    alu_zero    = 1'b0;
    alu_sgn     = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    @(negedge cpu_clk);
    do_reset();

    fetch(32'h0000_0013, 0, 0, 1'b0);
    exec(3'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("first_addr", imem_addr, 32'h4);

    br(3'd1, 1'b1, 1'b0, 32'h0000_00F0);
    br(3'd1, 1'b0, 1'b0, 32'h0000_0104);
    br(3'd2, 1'b0, 1'b0, 32'h0000_00F0);
    br(3'd2, 1'b1, 1'b0, 32'h0000_0104);
    br(3'd3, 1'b0, 1'b1, 32'h0000_00F0);
    br(3'd4, 1'b0, 1'b1, 32'h0000_0104);
    br(3'd3, 1'b0, 1'b0, 32'h0000_0104);
    br(3'd4, 1'b0, 1'b0, 32'h0000_00F0);
    br(3'd7, 1'b1, 1'b1, 32'h0000_0104);

    goto(32'h40);
    fetch(32'h0000_8067, 0, 0, 1'b0);
    chk("jalr_pc4", pc4, 32'h44);
    exec(3'd6, 32'h0, 32'h0000_2001, 1'b0, 1'b0);
    chk("jalr_tgt", pc, 32'h2000);

    goto(32'hFFFF_FFFC);
    fetch(32'h0000_0013, 0, 0, 1'b0);
    exec(3'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("wrap", pc, 32'h0);

    fetch(32'h0000_0013, 5, 2, 1'b0);
    exec(3'd0, 32'h0, 32'h0, 1'b0, 1'b0);

    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    chk("wait_state", {31'b0, imem_req}, 32'h0);
    do_reset();
    chk("stale_req", {31'b0, imem_req}, 32'h1);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    chk("stale_inst", inst, 32'h0);
    chk("stale_ivld", {31'b0, inst_valid}, 32'h0);
    chk("refetch", imem_addr, RST_PC);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] off;
      logic [31:0] base;
      off  = {$urandom_range(0, 255), 2'b00} - 32'd512;
      base = $urandom & 32'hFFFF_FFFD;
      fetch($urandom, $urandom_range(0, 3),
            $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      exec(3'($urandom_range(0, 7)), off, base,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    goto(32'h10);
    fetch(32'h0000_006F, 0, 0, 1'b0);
    exec(3'd5, 32'h6, 32'h0, 1'b0, 1'b0);
    chk("trap_pc", pc, 32'h16);
    for (int i = 0; i < 10; i++) begin
      imem_rvalid = 1'($urandom_range(0, 1));
      imem_gnt    = 1'($urandom_range(0, 1));
      tick();
      chk("trap_req_hold", {31'b0, imem_req}, 32'h0);
      chk("trap_mis_hold", {31'b0, misalign}, 32'h1);
      chk("trap_pc_hold", pc, 32'h16);
    end
    imem_rvalid = 1'b0;
    imem_gnt    = 1'b0;
    do_reset();
    chk("post_trap_req", {31'b0, imem_req}, 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
